min_order_dispatcher: RTL and testbench
=======================================

MIN_ORDER_DISPATCHER -- requirements
Module: min_order_dispatcher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each channel value.
REQ-002 SHALL have parameter CHANNEL_COUNT, default 8: number of channels in a batch (>=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port load_valid  input  1  batch offered.
REQ-006 SHALL have port load_ready  output  1  batch can be accepted.
REQ-007 SHALL have port load_values  input  DATA_WIDTH*CHANNEL_COUNT  channel i value in bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-008 SHALL have port load_valids  input  CHANNEL_COUNT  per-channel request mask.
REQ-009 SHALL have port out_valid  output  1  dispatch entry presented.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the entry.
REQ-011 SHALL have port out_value  output  DATA_WIDTH  value of the presented entry.
REQ-012 SHALL have port out_onehot  output  CHANNEL_COUNT  one-hot winner channel.
REQ-013 SHALL have port out_index  output  $clog2(CHANNEL_COUNT)  binary winner channel.
REQ-014 SHALL have port out_last  output  1  presented entry is the final one of the batch.
REQ-015 SHALL have port busy  output  1  batch in progress (state not IDLE).

Function
REQ-016 SHALL implement FSM states IDLE, SELECT, PRESENT.
REQ-017 IDLE: load_ready=1; on load_valid and nonzero load_valids, SHALL register values and mask into pending storage and go to SELECT.
REQ-018 IDLE: load_valid with load_valids==0 SHALL be accepted and discarded; state stays IDLE, no output.
REQ-019 SELECT: SHALL register the minimum pending value, its one-hot, index and out_last (popcount(pending)==1) and go to PRESENT; load_ready=0.
REQ-020 Comparison SHALL be unsigned; on equal values the lowest channel index SHALL win.
REQ-021 PRESENT: out_valid=1; all out_* SHALL remain stable until out_valid && out_ready.
REQ-022 On handshake SHALL clear the winner bit in pending; if pending becomes empty go to IDLE, else to SELECT.
REQ-023 Latency: load accepted at edge t SHALL yield out_valid at t+2; each subsequent entry 2 cycles after previous handshake (when out_ready held high).
REQ-024 load_ready SHALL be 0 in SELECT and PRESENT; a batch SHALL NOT be accepted in the cycle the last entry drains (earliest accept is the following IDLE cycle).
REQ-025 Entries SHALL be dispatched in non-decreasing value order; each valid channel exactly once.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, pending=0, out_valid=0, out_value=0, out_onehot=0, out_index=0, out_last=0, busy=0; load_ready=1 while reset_n low and after release.
REQ-027 Reset mid-batch SHALL discard the batch without emitting further entries.

Configuration
REQ-028 With MIN_ORDER_DISPATCHER_FLUSH_EN defined SHALL add input flush (1 bit): when high in SELECT/PRESENT, next state IDLE, pending cleared, out_valid deasserted next cycle, no handshake counted even if out_ready high; ignored in IDLE.
REQ-029 Without MIN_ORDER_DISPATCHER_FLUSH_EN the flush port SHALL not exist; batches only terminate by draining or reset.

Structure
REQ-030 Shared package dispatch_pkg SHALL hold the FSM state typedef and index-width helper constant.
REQ-031 The combinational minimum-with-index selection (values+mask -> min value, one-hot, index) SHALL be sub-module pending_min_select.

Verification
REQ-032 CHANNEL_COUNT=8, values ch0=5,ch1=3,ch2=9,ch3=3, valids=0x0F, out_ready=1 -> entries idx1(3), idx3(3), idx0(5), idx2(9, out_last=1), then load_ready=1.
REQ-033 load_valid=1, load_valids=0x00 -> no out_valid ever, load_ready stays 1, busy stays 0.
REQ-034 Batch valids=0x81 values ch0=7, ch7=2, out_ready low 10 cycles -> out_value=2, out_onehot=0x80, out_index=7 stable throughout; then idx0 after handshake.
REQ-035 All 8 valid, out_ready=1 constantly -> 8 entries in 16 cycles, first out_valid 2 cycles after load; reset_n low during 4th entry -> out_valid=0 same cycle, no further entries.
REQ-036 MIN_ORDER_DISPATCHER_FLUSH_EN defined, flush=1 during PRESENT of 2nd of 4 entries -> IDLE next cycle, load_ready=1, remaining 2 entries never emitted.

Source files
------------

// File: rtl/dispatch_pkg.sv
// dispatch_pkg
// Shared definitions for the min-order dispatcher slice:
//   state_e   - dispatcher FSM state encoding (IDLE, SELECT, PRESENT)
//   idx_width - width of a binary channel index for a given channel count
package dispatch_pkg;

    localparam int unsigned MIN_CHANNEL_COUNT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        PRESENT = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < MIN_CHANNEL_COUNT) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/min_order_dispatcher_if.sv
// min_order_dispatcher_if
// Batch-load and dispatch-output handshake bundle.
//   load_valid/load_ready/load_values/load_valids : batch offer (master -> slave)
//   out_valid/out_ready                           : entry handshake (slave -> master)
//   out_value/out_onehot/out_index/out_last       : presented entry
// master = batch producer / entry consumer, slave = dispatcher.
import dispatch_pkg::*;

interface min_order_dispatcher_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned CHANNEL_COUNT = 8
);
    localparam int unsigned IW = idx_width(CHANNEL_COUNT);

    logic                                load_valid;
    logic                                load_ready;
    logic [DATA_WIDTH*CHANNEL_COUNT-1:0] load_values;
    logic [CHANNEL_COUNT-1:0]            load_valids;
    logic                                out_valid;
    logic                                out_ready;
    logic [DATA_WIDTH-1:0]               out_value;
    logic [CHANNEL_COUNT-1:0]            out_onehot;
    logic [IW-1:0]                       out_index;
    logic                                out_last;

    modport master (
        output load_valid, load_values, load_valids, out_ready,
        input  load_ready, out_valid, out_value, out_onehot, out_index, out_last
    );

    modport slave (
        input  load_valid, load_values, load_valids, out_ready,
        output load_ready, out_valid, out_value, out_onehot, out_index, out_last
    );

endinterface

// File: rtl/pending_min_select.sv
// pending_min_select
// Combinational unsigned minimum over the masked channels.
//   values    : packed channel values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valids    : channel mask
//   min_value : smallest masked value (0 when mask empty)
//   min_onehot/min_index : winning channel; ties go to the lowest index
//   any       : mask non-empty
import dispatch_pkg::*;

module pending_min_select #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned CHANNEL_COUNT = 8,
    parameter int unsigned IW            = idx_width(CHANNEL_COUNT)
) (
    input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] values,
    input  logic [CHANNEL_COUNT-1:0]            valids,
    output logic [DATA_WIDTH-1:0]               min_value,
    output logic [CHANNEL_COUNT-1:0]            min_onehot,
    output logic [IW-1:0]                       min_index,
    output logic                                any
);

    always_comb begin
        any       = 1'b0;
        min_value = '0;
        min_index = '0;
        // Strict less-than keeps the earlier (lower) channel on ties.
        for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
            if (valids[i] && (!any || (values[i*DATA_WIDTH +: DATA_WIDTH] < min_value))) begin
                any       = 1'b1;
                min_value = values[i*DATA_WIDTH +: DATA_WIDTH];
                min_index = IW'(i);
            end
        end
        min_onehot = any ? (CHANNEL_COUNT'(1) << min_index) : '0;
    end

endmodule

// File: rtl/min_order_dispatcher.sv
// min_order_dispatcher
// Accepts a batch of channel values plus a request mask and emits the masked
// channels one at a time in non-decreasing value order (ties: lowest index).
//   clk, reset_n : clock, asynchronous active-low reset
//   busy         : batch in progress
//   flush        : abandon current batch (only with MIN_ORDER_DISPATCHER_FLUSH_EN)
//   bus          : load/out handshake bundle (slave side)
// Each entry costs one SELECT cycle (register the minimum) and at least one
// PRESENT cycle (hold until out_ready).
import dispatch_pkg::*;

module min_order_dispatcher #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned CHANNEL_COUNT = 8
) (
    input  logic clk,
    input  logic reset_n,
`ifdef MIN_ORDER_DISPATCHER_FLUSH_EN
    input  logic flush,
`endif
    output logic busy,
    min_order_dispatcher_if.slave bus
);

    localparam int unsigned IW = idx_width(CHANNEL_COUNT);

    state_e                              state_q, state_d;
    logic [DATA_WIDTH*CHANNEL_COUNT-1:0] values_q, values_d;
    logic [CHANNEL_COUNT-1:0]            pending_q, pending_d;
    logic [DATA_WIDTH-1:0]               out_value_q, out_value_d;
    logic [CHANNEL_COUNT-1:0]            out_onehot_q, out_onehot_d;
    logic [IW-1:0]                       out_index_q, out_index_d;
    logic                                out_last_q, out_last_d;

    logic [DATA_WIDTH-1:0]               sel_value;
    logic [CHANNEL_COUNT-1:0]            sel_onehot;
    logic [IW-1:0]                       sel_index;
    logic                                sel_any;
    logic                                flush_req;

`ifdef MIN_ORDER_DISPATCHER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    pending_min_select #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CHANNEL_COUNT(CHANNEL_COUNT),
        .IW           (IW)
    ) u_sel (
        .values    (values_q),
        .valids    (pending_q),
        .min_value (sel_value),
        .min_onehot(sel_onehot),
        .min_index (sel_index),
        .any       (sel_any)
    );

    always_comb begin
        state_d      = state_q;
        values_d     = values_q;
        pending_d    = pending_q;
        out_value_d  = out_value_q;
        out_onehot_d = out_onehot_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;

        case (state_q)
            IDLE: begin
                // An empty-mask offer is consumed (load_ready is high) but ignored.
                if (bus.load_valid && (|bus.load_valids)) begin
                    values_d  = bus.load_values;
                    pending_d = bus.load_valids;
                    state_d   = SELECT;
                end
            end
            SELECT: begin
                if (sel_any) begin
                    out_value_d  = sel_value;
                    out_onehot_d = sel_onehot;
                    out_index_d  = sel_index;
                    // Exactly one pending bit left means this is the final entry.
                    out_last_d   = ((pending_q & (pending_q - CHANNEL_COUNT'(1))) == '0);
                    state_d      = PRESENT;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    pending_d = pending_q & ~out_onehot_q;
                    state_d   = (pending_d == '0) ? IDLE : SELECT;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides any handshake taken in the same cycle.
        if (flush_req && (state_q != IDLE)) begin
            state_d   = IDLE;
            pending_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            values_q     <= '0;
            pending_q    <= '0;
            out_value_q  <= '0;
            out_onehot_q <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            values_q     <= values_d;
            pending_q    <= pending_d;
            out_value_q  <= out_value_d;
            out_onehot_q <= out_onehot_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.out_valid  = (state_q == PRESENT);
    assign bus.out_value  = out_value_q;
    assign bus.out_onehot = out_onehot_q;
    assign bus.out_index  = out_index_q;
    assign bus.out_last   = out_last_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_min_order_dispatcher.sv
// tb_min_order_dispatcher
// Directed, table-driven bench for min_order_dispatcher (8 channels x 8 bits).
// Inputs change and outputs are sampled on the falling clock edge.
// Flush scenario is compiled only with MIN_ORDER_DISPATCHER_FLUSH_EN.
module tb_min_order_dispatcher;

    typedef struct packed {
        logic [63:0] values;   // {ch7, ..., ch0}
        logic [7:0]  valids;
        logic [3:0]  n;        // number of entries expected
        logic [23:0] order;    // expected channel of entry k at [k*3 +: 3]
    } vec_t;

    logic clk;
    logic reset_n;
    logic busy;
`ifdef MIN_ORDER_DISPATCHER_FLUSH_EN
    logic flush;
`endif

    int checks;
    int errors;
    int cur_case;

    vec_t vecs [5];

    min_order_dispatcher_if #(.DATA_WIDTH(8), .CHANNEL_COUNT(8)) bus ();

    min_order_dispatcher #(.DATA_WIDTH(8), .CHANNEL_COUNT(8)) dut (
        .clk    (clk),
        .reset_n(reset_n),
`ifdef MIN_ORDER_DISPATCHER_FLUSH_EN
        .flush  (flush),
`endif
        .busy   (busy),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (case %0d): got %0h, expected %0h", name, cur_case, act, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid",  bus.out_valid,  1'b0);
        chk("rst_out_value",  bus.out_value,  8'h00);
        chk("rst_out_onehot", bus.out_onehot, 8'h00);
        chk("rst_out_index",  bus.out_index,  3'd0);
        chk("rst_out_last",   bus.out_last,   1'b0);
        chk("rst_busy",       busy,           1'b0);
        chk("rst_load_ready", bus.load_ready, 1'b1);
    endtask

    // Called on a falling edge with the DUT idle; returns on a falling edge, idle.
    task automatic run_vec(input vec_t v);
        int unsigned k;
        int          n;
        logic [2:0]  idx;
        logic [7:0]  exp_oh;
        n = int'(v.n);
        chk("pre_load_ready", bus.load_ready, 1'b1);
        bus.load_values = v.values;
        bus.load_valids = v.valids;
        bus.load_valid  = 1'b1;
        bus.out_ready   = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk("accept_busy",  busy,           1'b1);
        chk("accept_ready", bus.load_ready, 1'b0);
        chk("accept_valid", bus.out_valid,  1'b0);
        for (int c = 1; c <= 2 * n + 1; c++) begin
            @(negedge clk);
            if ((c % 2 == 1) && (c < 2 * n)) begin
                k      = (c - 1) / 2;
                idx    = v.order[k*3 +: 3];
                exp_oh = 8'b1 << idx;
                chk("entry_valid",  bus.out_valid,  1'b1);
                chk("entry_index",  bus.out_index,  idx);
                chk("entry_onehot", bus.out_onehot, exp_oh);
                chk("entry_value",  bus.out_value,  v.values[int'(idx)*8 +: 8]);
                chk("entry_last",   bus.out_last,   (k == n - 1));
                chk("entry_ready",  bus.load_ready, 1'b0);
            end else if (c == 2 * n) begin
                chk("drain_valid", bus.out_valid,  1'b0);
                chk("drain_ready", bus.load_ready, 1'b1);
                chk("drain_busy",  busy,           1'b0);
            end else begin
                chk("gap_valid", bus.out_valid, 1'b0);
            end
        end
    endtask

    initial begin
        logic seen_valid;
        logic seen_not_ready;
        logic seen_busy;

        checks   = 0;
        errors   = 0;
        cur_case = 0;

        vecs[0] = '{values: 64'h00000000_03090305, valids: 8'h0F, n: 4'd4,
                    order: {12'd0, 3'd2, 3'd0, 3'd3, 3'd1}};
        vecs[1] = '{values: 64'h02000000_00000007, valids: 8'h81, n: 4'd2,
                    order: {18'd0, 3'd0, 3'd7}};
        vecs[2] = '{values: 64'h017F8010_00FF1040, valids: 8'hFF, n: 4'd8,
                    order: {3'd2, 3'd5, 3'd6, 3'd0, 3'd4, 3'd1, 3'd7, 3'd3}};
        vecs[3] = '{values: 64'h00003300_00000000, valids: 8'h20, n: 4'd1,
                    order: {21'd0, 3'd5}};
        vecs[4] = '{values: 64'h55555555_55555555, valids: 8'hA5, n: 4'd4,
                    order: {12'd0, 3'd7, 3'd5, 3'd2, 3'd0}};

        reset_n         = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_values = '0;
        bus.load_valids = '0;
        bus.out_ready   = 1'b1;
`ifdef MIN_ORDER_DISPATCHER_FLUSH_EN
        flush = 1'b0;
`endif

        // Reset state, while held and after release.
        #3;
        chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cur_case = 1;
        chk_reset_outputs();

        // Table-driven batches, out_ready held high.
        for (int i = 0; i < 5; i++) begin
            cur_case = 10 + i;
            run_vec(vecs[i]);
        end

        // Empty mask is swallowed.
        cur_case = 20;
        bus.load_values = 64'h11223344_55667788;
        bus.load_valids = 8'h00;
        bus.load_valid  = 1'b1;
        seen_valid = 1'b0; seen_not_ready = 1'b0; seen_busy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.load_valid = 1'b0;
            seen_valid     |= bus.out_valid;
            seen_not_ready |= ~bus.load_ready;
            seen_busy      |= busy;
        end
        chk("empty_no_valid",   seen_valid,     1'b0);
        chk("empty_ready_held", seen_not_ready, 1'b0);
        chk("empty_not_busy",   seen_busy,      1'b0);

        // Backpressure: winner ch7 held stable for 10 cycles, then ch0.
        cur_case = 30;
        bus.load_values = vecs[1].values;
        bus.load_valids = 8'h81;
        bus.load_valid  = 1'b1;
        bus.out_ready   = 1'b0;
        @(negedge clk);
        bus.load_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("bp_valid",  bus.out_valid,  1'b1);
            chk("bp_value",  bus.out_value,  8'h02);
            chk("bp_onehot", bus.out_onehot, 8'h80);
            chk("bp_index",  bus.out_index,  3'd7);
            chk("bp_last",   bus.out_last,   1'b0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_select_gap", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("bp2_valid", bus.out_valid, 1'b1);
        chk("bp2_value", bus.out_value, 8'h07);
        chk("bp2_index", bus.out_index, 3'd0);
        chk("bp2_last",  bus.out_last,  1'b1);
        @(negedge clk);
        chk("bp_done_ready", bus.load_ready, 1'b1);

        // Offer held during the draining PRESENT cycle: accepted only in IDLE.
        cur_case = 40;
        bus.load_values = vecs[3].values;
        bus.load_valids = vecs[3].valids;
        bus.load_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_present", bus.out_valid,  1'b1);
        chk("hold_ready0",  bus.load_ready, 1'b0);
        @(negedge clk);
        chk("hold_idle_ready", bus.load_ready, 1'b1);
        chk("hold_idle_busy",  busy,           1'b0);
        chk("hold_idle_valid", bus.out_valid,  1'b0);
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk("hold_reaccept_busy", busy, 1'b1);
        @(negedge clk);
        chk("hold_second_valid", bus.out_valid, 1'b1);
        chk("hold_second_index", bus.out_index, 3'd5);
        @(negedge clk);
        chk("hold_second_done", busy, 1'b0);

        // Reset during the 4th entry of a full batch.
        cur_case = 50;
        bus.load_values = vecs[2].values;
        bus.load_valids = 8'hFF;
        bus.load_valid  = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        for (int c = 1; c <= 7; c++) @(negedge clk);
        chk("mid_valid", bus.out_valid, 1'b1);
        chk("mid_index", bus.out_index, 3'd4);
        reset_n = 1'b0;
        #1;
        cur_case = 51;
        chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            seen_valid |= bus.out_valid;
        end
        chk("mid_no_more_entries", seen_valid, 1'b0);

`ifdef MIN_ORDER_DISPATCHER_FLUSH_EN
        // Flush while the 2nd of 4 entries is presented.
        cur_case = 60;
        bus.load_values = vecs[0].values;
        bus.load_valids = vecs[0].valids;
        bus.load_valid  = 1'b1;
        bus.out_ready   = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        for (int c = 1; c <= 3; c++) @(negedge clk);
        chk("fl_second_valid", bus.out_valid, 1'b1);
        chk("fl_second_index", bus.out_index, 3'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", bus.out_valid,  1'b0);
        chk("fl_ready", bus.load_ready, 1'b1);
        chk("fl_busy",  busy,           1'b0);
        seen_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen_valid |= bus.out_valid;
        end
        chk("fl_no_more_entries", seen_valid, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
